// File: rtl/dataram_wr_arbiter.sv
// Write-slot admission for the data-RAM occupancy shift register: grants W/E/S/N/LF
// write requests that collide neither with booked slots nor with each other.

module dataram_wr_arbiter_starve #(
  parameter int STARVE_MAX = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vld,
  input  logic i_gnt,
  output logic o_starved
);
  logic [2:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_cnt <= '0;
    else if (!i_vld || i_gnt)           r_cnt <= '0;
    else if (r_cnt != 3'(STARVE_MAX))   r_cnt <= r_cnt + 3'd1;
  end

  assign o_starved = (r_cnt == 3'(STARVE_MAX));
endmodule

module dataram_wr_arbiter #(
  parameter int RAM_SHIFT_REG_WIDTH = 20,
  parameter int DLY_W      = 2,
  parameter int DLY_E      = 2,
  parameter int DLY_S      = 4,
  parameter int DLY_N      = 4,
  parameter int DLY_LF     = 1,
  parameter int STARVE_MAX = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_w_req_vld,
  input  logic       i_e_req_vld,
  input  logic       i_s_req_vld,
  input  logic       i_n_req_vld,
  input  logic       i_lf_req_vld,
  input  logic [2:0] i_w_req_ram_sel,
  input  logic [2:0] i_e_req_ram_sel,
  input  logic [2:0] i_s_req_ram_sel,
  input  logic [2:0] i_n_req_ram_sel,
  input  logic [2:0] i_lf_req_ram_sel,
  output logic       o_w_req_rdy,
  output logic       o_e_req_rdy,
  output logic       o_s_req_rdy,
  output logic       o_n_req_rdy,
  output logic       o_lf_req_rdy,
  input  logic [7:0][RAM_SHIFT_REG_WIDTH-1:0] i_ram_shift_reg,
  output logic       o_w_dataram_wr_vld,
  output logic       o_e_dataram_wr_vld,
  output logic       o_s_dataram_wr_vld,
  output logic       o_n_dataram_wr_vld,
  output logic       o_linefill_req_vld,
  output logic [2:0] o_w_wr_ram_sel,
  output logic [2:0] o_e_wr_ram_sel,
  output logic [2:0] o_s_wr_ram_sel,
  output logic [2:0] o_n_wr_ram_sel,
  output logic [2:0] o_lf_wr_ram_sel
);
  localparam int NUM_CH  = 5;   // 0..3 = W,E,S,N ; 4 = LF
  localparam int SW      = $clog2(RAM_SHIFT_REG_WIDTH);
  localparam int MAX_DLY = (DLY_W > DLY_E ? DLY_W : DLY_E) > (DLY_S > DLY_N ? DLY_S : DLY_N)
                         ? ((DLY_W > DLY_E ? DLY_W : DLY_E) > DLY_LF ? (DLY_W > DLY_E ? DLY_W : DLY_E) : DLY_LF)
                         : ((DLY_S > DLY_N ? DLY_S : DLY_N) > DLY_LF ? (DLY_S > DLY_N ? DLY_S : DLY_N) : DLY_LF);

  // Worst-case probe bit is max delay + block delay 8 + 1.
  if (MAX_DLY + 9 > RAM_SHIFT_REG_WIDTH - 1) begin : g_bad_param
    $error("dataram_wr_arbiter: occupancy vector too narrow for configured delays");
  end

  function automatic int f_dly(input int ch);
    case (ch)
      0:       return DLY_W;
      1:       return DLY_E;
      2:       return DLY_S;
      3:       return DLY_N;
      default: return DLY_LF;
    endcase
  endfunction

  function automatic logic f_clash(input logic [NUM_CH-1:0] gnt,
                                   input logic [NUM_CH-1:0][2:0] sel,
                                   input logic [NUM_CH-1:0][SW-1:0] slot,
                                   input logic [2:0] ch);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < NUM_CH; j++)
      if (gnt[j] && sel[j] == sel[ch] && slot[j] == slot[ch]) hit = 1'b1;
    return hit;
  endfunction

  logic [NUM_CH-1:0]          w_vld;
  logic [NUM_CH-1:0][2:0]     w_sel;
  logic [NUM_CH-1:0][SW-1:0]  w_slot;
  logic [NUM_CH-1:0]          w_occ;
  logic [NUM_CH-1:0]          w_gnt;
  logic [3:0]                 w_starved;
  logic [3:0][1:0]            w_rr_ch;
  logic [1:0]                 w_rr_nxt;
  logic [1:0]                 r_rr_ptr;

  assign w_vld = {i_lf_req_vld, i_n_req_vld, i_s_req_vld, i_e_req_vld, i_w_req_vld};
  assign w_sel = {i_lf_req_ram_sel, i_n_req_ram_sel, i_s_req_ram_sel,
                  i_e_req_ram_sel, i_w_req_ram_sel};

  // Probe slot+1: that bit lands in [slot] on the edge our reservation is written.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
    assign w_slot[c] = SW'(f_dly(c) + 8 - int'(w_sel[c][2:1]));
    assign w_occ[c]  = i_ram_shift_reg[w_sel[c]][w_slot[c] + SW'(1)];
  end

  for (genvar k = 0; k < 4; k++) begin : g_rr
    assign w_rr_ch[k] = r_rr_ptr + 2'(k);
  end

  dataram_wr_arbiter_starve #(.STARVE_MAX(STARVE_MAX)) u_starve [3:0] (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_vld     (w_vld[3:0]),
    .i_gnt     (w_gnt[3:0]),
    .o_starved (w_starved)
  );

  // Priority walk: LF, then starved lanes W..N, then the rest in round-robin order.
  always_comb begin
    w_gnt = '0;
    if (rst_n) begin
      w_gnt[4] = w_vld[4] & ~w_occ[4];
      for (int k = 0; k < 4; k++)
        if (w_starved[k] && w_vld[k] && !w_occ[k] && !f_clash(w_gnt, w_sel, w_slot, 3'(k)))
          w_gnt[k] = 1'b1;
      for (int k = 0; k < 4; k++)
        if (!w_starved[w_rr_ch[k]] && w_vld[{1'b0, w_rr_ch[k]}] && !w_occ[{1'b0, w_rr_ch[k]}]
            && !f_clash(w_gnt, w_sel, w_slot, {1'b0, w_rr_ch[k]}))
          w_gnt[{1'b0, w_rr_ch[k]}] = 1'b1;
    end
  end

  // Descending walk leaves the first granted lane in round-robin order.
  always_comb begin
    w_rr_nxt = r_rr_ptr;
    for (int k = 3; k >= 0; k--)
      if (w_gnt[{1'b0, w_rr_ch[k]}]) w_rr_nxt = w_rr_ch[k] + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rr_ptr <= 2'd0;
    else        r_rr_ptr <= w_rr_nxt;
  end

  assign o_w_req_rdy        = w_gnt[0];
  assign o_e_req_rdy        = w_gnt[1];
  assign o_s_req_rdy        = w_gnt[2];
  assign o_n_req_rdy        = w_gnt[3];
  assign o_lf_req_rdy       = w_gnt[4];
  assign o_w_dataram_wr_vld = w_gnt[0];
  assign o_e_dataram_wr_vld = w_gnt[1];
  assign o_s_dataram_wr_vld = w_gnt[2];
  assign o_n_dataram_wr_vld = w_gnt[3];
  assign o_linefill_req_vld = w_gnt[4];
  assign o_w_wr_ram_sel     = i_w_req_ram_sel;
  assign o_e_wr_ram_sel     = i_e_req_ram_sel;
  assign o_s_wr_ram_sel     = i_s_req_ram_sel;
  assign o_n_wr_ram_sel     = i_n_req_ram_sel;
  assign o_lf_wr_ram_sel    = i_lf_req_ram_sel;
endmodule

// File: tb/tb_dataram_wr_arbiter.sv
// Directed bench for dataram_wr_arbiter; runs with DLY_W=1 so W and LF can collide on a slot.

module tb_dataram_wr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic w_vld, e_vld, s_vld, n_vld, lf_vld;
  logic [2:0] w_sel, e_sel, s_sel, n_sel, lf_sel;
  logic w_rdy, e_rdy, s_rdy, n_rdy, lf_rdy;
  logic [7:0][19:0] occ;
  logic w_wv, e_wv, s_wv, n_wv, lf_wv;
  logic [2:0] w_os, e_os, s_os, n_os, lf_os;

  typedef struct {
    string      tag;
    logic [4:0] gnt;
    logic [14:0] sels;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dataram_wr_arbiter #(.RAM_SHIFT_REG_WIDTH(20), .DLY_W(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_w_req_vld(w_vld), .i_e_req_vld(e_vld), .i_s_req_vld(s_vld),
    .i_n_req_vld(n_vld), .i_lf_req_vld(lf_vld),
    .i_w_req_ram_sel(w_sel), .i_e_req_ram_sel(e_sel), .i_s_req_ram_sel(s_sel),
    .i_n_req_ram_sel(n_sel), .i_lf_req_ram_sel(lf_sel),
    .o_w_req_rdy(w_rdy), .o_e_req_rdy(e_rdy), .o_s_req_rdy(s_rdy),
    .o_n_req_rdy(n_rdy), .o_lf_req_rdy(lf_rdy),
    .i_ram_shift_reg(occ),
    .o_w_dataram_wr_vld(w_wv), .o_e_dataram_wr_vld(e_wv), .o_s_dataram_wr_vld(s_wv),
    .o_n_dataram_wr_vld(n_wv), .o_linefill_req_vld(lf_wv),
    .o_w_wr_ram_sel(w_os), .o_e_wr_ram_sel(e_os), .o_s_wr_ram_sel(s_os),
    .o_n_wr_ram_sel(n_os), .o_lf_wr_ram_sel(lf_os)
  );

  wire [4:0]  rdy_v = {lf_rdy, n_rdy, s_rdy, e_rdy, w_rdy};
  wire [4:0]  wv_v  = {lf_wv, n_wv, s_wv, e_wv, w_wv};
  wire [14:0] os_v  = {lf_os, n_os, s_os, e_os, w_os};

  // Expected grant vector {LF,N,S,E,W} queued with the stimulus, checked 1 time unit later.
  task automatic step(input string tag, input logic [4:0] gnt);
    exp_t e;
    e.tag  = tag;
    e.gnt  = gnt;
    e.sels = {lf_sel, n_sel, s_sel, e_sel, w_sel};
    sbq.push_back(e);
    #1;
    e = sbq.pop_front();
    total++;
    assert (rdy_v === e.gnt) else begin
      bad++;
      $error("FAIL %s rdy got=%b exp=%b", e.tag, rdy_v, e.gnt);
    end
    total++;
    assert (wv_v === e.gnt) else begin
      bad++;
      $error("FAIL %s wr_vld got=%b exp=%b", e.tag, wv_v, e.gnt);
    end
    total++;
    assert (os_v === e.sels) else begin
      bad++;
      $error("FAIL %s wr_ram_sel got=%h exp=%h", e.tag, os_v, e.sels);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    {w_vld, e_vld, s_vld, n_vld, lf_vld} = '0;
    occ = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    occ   = '0;
    {w_vld, e_vld, s_vld, n_vld, lf_vld} = 5'b11111;
    w_sel = 3'd0; e_sel = 3'd2; s_sel = 3'd4; n_sel = 3'd6; lf_sel = 3'd1;
    @(negedge clk);
    @(negedge clk);
    step("reset_hold", 5'b00000);
    rst_n = 1'b1;
    step("reset_release", 5'b11111);          // rr -> E

    idle();
    w_vld = 1'b1; w_sel = 3'd0;               // W slot 9
    occ[0][10] = 1'b1;
    step("occ_block", 5'b00000);
    occ = '0;
    occ[0][9] = 1'b1; occ[0][11] = 1'b1;
    step("occ_clear", 5'b00001);              // rr stays E

    idle();
    s_vld = 1'b1; n_vld = 1'b1; s_sel = 3'd2; n_sel = 3'd2;
    step("pair_rrE", 5'b00100);               // rr -> N

    idle();
    lf_vld = 1'b1; lf_sel = 3'd2; w_vld = 1'b1; w_sel = 3'd2;
    step("lf_over_w", 5'b10000);              // rr stays N

    idle();
    s_vld = 1'b1; n_vld = 1'b1; s_sel = 3'd2; n_sel = 3'd2;
    step("pair_rrN", 5'b01000);               // rr -> W

    idle();
    step("idle", 5'b00000);

    n_vld = 1'b1; n_sel = 3'd4;               // N slot 10
    occ[4][11] = 1'b1;
    for (int i = 0; i < 6; i++) step($sformatf("starve_blk%0d", i), 5'b00000);
    occ = '0;
    w_vld = 1'b1; w_sel = 3'd0; s_vld = 1'b1; s_sel = 3'd4;
    step("starve_cnt6", 5'b00101);            // N count reaches 7, rr -> E
    w_vld = 1'b0;
    step("starve_escalate", 5'b01000);        // rr -> W
    step("starve_cleared", 5'b00100);

    idle();
    lf_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lf_sel = 3'(2 * i);
      occ = '0;
      occ[2*i][10-i] = 1'b1;
      step($sformatf("blk_hit%0d", i), 5'b00000);
      occ = '0;
      occ[2*i][9-i] = 1'b1;
      occ[2*i][11-i] = 1'b1;
      occ[2*i+1][10-i] = 1'b1;
      step($sformatf("blk_free%0d", i), 5'b10000);
    end

    idle();
    rst_n = 1'b0;
    {w_vld, e_vld, s_vld, n_vld, lf_vld} = 5'b11111;
    step("reset_mid", 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
